scan_seq_ctrl: RTL and testbench
================================

Name: scan_seq_ctrl

Overview:
- Parametrised successor of the rotation/RF-switch/ADC process sequencer.
- Per position: pulse the stepper enable, wait for settling, then visit every RF channel selected by a runtime mask (switch setup, then ADC window), then advance the rotation count.
- Sits between the trigger/init control logic and the stepper driver, RF switch bank and ADC front end.
- Timing is counted in stp_clk ticks; all logic runs on fpga_clk.

Parameters:
- N_CH, 4, number of RF channels (2..16).
- CNT_W, 10, rotation counter width.
- N_ROT, 720, positions per scan (1..2^CNT_W-1).
- ROT_TICKS, 5, rot_en high time in ticks (>=1).
- SETTLE_TICKS, 100, ticks from rot_en fall to first switch setup (>=1).
- SW_TICKS, 3, ticks from rf_sw change to adc_en rise (>=1).
- ADC_TICKS, 30, adc_en high time in ticks (>=1).

Ports:
- fpga_clk  in  1  system clock.
- sys_init_ctrl  in  1  asynchronous active-high reset.
- stp_clk  in  1  asynchronous step timebase; each rising edge is one tick.
- trg_ctrl  in  1  start-scan request, level, sampled in IDLE only.
- abort_ctrl  in  1  synchronous abort, level.
- ch_mask  in  N_CH  channel enable mask, bit i = channel i.
- wrk_stat  out  1  scan in progress.
- rot_en  out  1  stepper enable.
- adc_en  out  1  ADC acquisition window.
- rf_sw  out  N_CH  one-hot RF switch select, or zero.
- adc_ch  out  clog2(N_CH)  index of the active channel.
- rot_count  out  CNT_W  completed positions.
- scan_done  out  1  one-cycle pulse when a scan completes.
- cfg_err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset: every output and all internal state go to 0 asynchronously; the FSM enters IDLE.
- Tick: stp_clk passes through a 2-flop synchroniser and a rising-edge detect, giving a 1-cycle tick 3 fpga_clk cycles after the stp_clk rise. All tick counters are CNT-style, cleared on state entry.
- IDLE:
  - trg_ctrl=1 and ch_mask!=0: latch mask to mask_q, clear rot_count, set wrk_stat, go to ROTATE.
  - trg_ctrl=1 and ch_mask==0: pulse cfg_err, stay in IDLE.
- ROTATE: rot_en=1 from entry. On the ROT_TICKS-th tick: rot_en=0, go to SETTLE.
- SETTLE: on the SETTLE_TICKS-th tick, select the lowest set bit of mask_q (rf_sw one-hot, adc_ch = index), go to SWSET.
- SWSET: on the SW_TICKS-th tick: adc_en=1, go to ACQ.
- ACQ: on the ADC_TICKS-th tick:
  - adc_en=0.
  - If a higher set bit exists in mask_q, switch rf_sw/adc_ch to it in the same cycle and go to SWSET.
  - Otherwise: rf_sw=0, rot_count+1, go to CHECK.
- CHECK (one fpga_clk):
  - rot_count==N_ROT: clear wrk_stat, pulse scan_done, go to IDLE. rot_count holds its final value until the next start.
  - Else go to ROTATE.
- ch_mask changes during a scan are ignored; mask_q applies until the scan ends.
- trg_ctrl while wrk_stat=1: ignored.
- abort_ctrl=1 in any non-IDLE state:
  - Next cycle: rot_en=0, adc_en=0, rf_sw=0, wrk_stat=0, go to IDLE.
  - rot_count keeps its value; no scan_done pulse.
- abort_ctrl and trg_ctrl in the same IDLE cycle: abort wins, no start.
- A tick arriving in CHECK or IDLE is dropped.
- rf_sw is never more than one-hot; adc_en is never high while rf_sw==0.

Optional Feature:
- SCAN_ZIGZAG_EN defined:
  - Adds output rot_dir (1 bit, reset 0).
  - rot_dir toggles in CHECK on every continuing position.
  - The channel visit order reverses on odd positions (highest set bit first).
- Undefined: no rot_dir port; ascending channel order always.

Decomposition:
- Package scan_seq_pkg holds:
  - FSM state enum: IDLE, ROTATE, SETTLE, SWSET, ACQ, CHECK.
  - Default timing constants.
  - Function next_set_bit(mask, idx, dir).
- Sub-module step_tick_gen: synchroniser plus rising-edge detect on stp_clk, producing the 1-cycle tick.

Test Plan:
Bench params: N_CH=4, N_ROT=3, ROT_TICKS=2, SETTLE_TICKS=4, SW_TICKS=1, ADC_TICKS=3.
- mask=4'b1111, trg -> per position rf_sw sequence 0001,0010,0100,1000, each with a 3-tick adc_en; rot_count reaches 3; one scan_done pulse; wrk_stat falls. Total ticks per position = 2+4+4*(1+3) = 22.
- mask=4'b1010, trg -> rf_sw 0010 then 1000, adc_ch 1 then 3; 2 ADC windows per position.
- mask=0, trg -> cfg_err pulses once; wrk_stat stays 0; no rot_en.
- abort asserted mid-ACQ on position 2 -> all enables 0 next cycle; rot_count=1; no scan_done; a new trg restarts with rot_count=0.
- Reset asserted mid-SETTLE -> all outputs 0 immediately, without waiting for a clock edge; trg after reset release starts a normal scan.
- SCAN_ZIGZAG_EN, mask=4'b0101 -> position 0 visits ch0 then ch2, position 1 visits ch2 then ch0; rot_dir=1 during position 1.

Source files
------------

// File: rtl/scan_seq_pkg.sv
// Shared FSM state type, default timing constants and channel-walk helper for scan_seq_ctrl.
package scan_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRotate,
        StSettle,
        StSwset,
        StAcq,
        StCheck
    } scan_state_e;

    localparam int unsigned MAX_CH           = 16;
    localparam int unsigned TCNT_W           = 16;
    localparam int unsigned DEF_N_CH         = 4;
    localparam int unsigned DEF_CNT_W        = 10;
    localparam int unsigned DEF_N_ROT        = 720;
    localparam int unsigned DEF_ROT_TICKS    = 5;
    localparam int unsigned DEF_SETTLE_TICKS = 100;
    localparam int unsigned DEF_SW_TICKS     = 3;
    localparam int unsigned DEF_ADC_TICKS    = 30;

    // Nearest set bit at or beyond idx, walking up (dir=0) or down (dir=1); -1 when none.
    function automatic int next_set_bit(input logic [MAX_CH-1:0] mask, input int idx,
                                        input logic dir);
        int res;
        res = -1;
        for (int i = 0; i < int'(MAX_CH); i++) begin
            if (mask[i] && !dir && res < 0 && i >= idx) res = i;
            if (mask[i] && dir && i <= idx) res = i;
        end
        return res;
    endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Brings the free-running stp_clk into the fpga_clk domain as a one-cycle tick per rising edge.
module step_tick_gen (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_stp_clk,
    output logic o_tick
);

    logic [2:0] r_sync;  // [1:0] two-flop synchroniser, [2] edge-detect history

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            o_tick <= 1'b0;
        end else begin
            r_sync <= {r_sync[1:0], i_stp_clk};
            o_tick <= r_sync[1] & ~r_sync[2];
        end
    end

endmodule

// File: rtl/scan_seq_ctrl.sv
// Rotation / RF-switch / ADC scan sequencer timed in stp_clk ticks.
// Define SCAN_ZIGZAG_EN to add rot_dir and reverse the channel order on odd positions.
module scan_seq_ctrl
    import scan_seq_pkg::*;
#(
    parameter int unsigned N_CH         = DEF_N_CH,
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter int unsigned N_ROT        = DEF_N_ROT,
    parameter int unsigned ROT_TICKS    = DEF_ROT_TICKS,
    parameter int unsigned SETTLE_TICKS = DEF_SETTLE_TICKS,
    parameter int unsigned SW_TICKS     = DEF_SW_TICKS,
    parameter int unsigned ADC_TICKS    = DEF_ADC_TICKS
) (
    input  logic                     fpga_clk,
    input  logic                     sys_init_ctrl,
    input  logic                     stp_clk,
    input  logic                     trg_ctrl,
    input  logic                     abort_ctrl,
    input  logic [N_CH-1:0]          ch_mask,
    output logic                     wrk_stat,
    output logic                     rot_en,
    output logic                     adc_en,
    output logic [N_CH-1:0]          rf_sw,
    output logic [$clog2(N_CH)-1:0]  adc_ch,
    output logic [CNT_W-1:0]         rot_count,
    output logic                     scan_done,
    output logic                     cfg_err
`ifdef SCAN_ZIGZAG_EN
    ,
    output logic                     rot_dir
`endif
);

    localparam int unsigned       CH_W        = $clog2(N_CH);
    localparam logic [TCNT_W-1:0] ROT_LAST    = TCNT_W'(ROT_TICKS - 1);
    localparam logic [TCNT_W-1:0] SETTLE_LAST = TCNT_W'(SETTLE_TICKS - 1);
    localparam logic [TCNT_W-1:0] SW_LAST     = TCNT_W'(SW_TICKS - 1);
    localparam logic [TCNT_W-1:0] ADC_LAST    = TCNT_W'(ADC_TICKS - 1);
    localparam logic [CNT_W-1:0]  ROT_END     = CNT_W'(N_ROT);

    scan_state_e       r_state;
    logic [TCNT_W-1:0] r_tcnt;
    logic [N_CH-1:0]   r_mask;
    logic              w_tick;
    logic              w_dir;
    logic              w_done;
    logic [MAX_CH-1:0] w_mask_ext;
    int                w_first;
    int                w_next;
    logic [N_CH-1:0]   w_first_sw;
    logic [N_CH-1:0]   w_next_sw;

    step_tick_gen u_tick (
        .i_clk     (fpga_clk),
        .i_rst     (sys_init_ctrl),
        .i_stp_clk (stp_clk),
        .o_tick    (w_tick)
    );

`ifdef SCAN_ZIGZAG_EN
    assign w_dir = rot_dir;
`else
    assign w_dir = 1'b0;
`endif

    always_comb begin
        w_mask_ext = '0;
        w_mask_ext[N_CH-1:0] = r_mask;
        w_first = next_set_bit(w_mask_ext, w_dir ? int'(N_CH) - 1 : 0, w_dir);
        w_next  = next_set_bit(w_mask_ext, w_dir ? int'(adc_ch) - 1 : int'(adc_ch) + 1, w_dir);
        w_first_sw = (w_first >= 0) ? (N_CH'(1) << w_first) : '0;
        w_next_sw  = (w_next >= 0) ? (N_CH'(1) << w_next) : '0;
    end

    // The current tick completes the interval of the current timed state.
    always_comb begin
        w_done = 1'b0;
        unique case (r_state)
            StRotate: w_done = w_tick && (r_tcnt == ROT_LAST);
            StSettle: w_done = w_tick && (r_tcnt == SETTLE_LAST);
            StSwset:  w_done = w_tick && (r_tcnt == SW_LAST);
            StAcq:    w_done = w_tick && (r_tcnt == ADC_LAST);
            default:  w_done = 1'b0;
        endcase
    end

    always_ff @(posedge fpga_clk or posedge sys_init_ctrl) begin
        if (sys_init_ctrl) begin
            r_state   <= StIdle;
            r_tcnt    <= '0;
            r_mask    <= '0;
            wrk_stat  <= 1'b0;
            rot_en    <= 1'b0;
            adc_en    <= 1'b0;
            rf_sw     <= '0;
            adc_ch    <= '0;
            rot_count <= '0;
            scan_done <= 1'b0;
            cfg_err   <= 1'b0;
`ifdef SCAN_ZIGZAG_EN
            rot_dir   <= 1'b0;
`endif
        end else begin
            scan_done <= 1'b0;
            cfg_err   <= 1'b0;
            if (w_tick) r_tcnt <= r_tcnt + 1'b1;
            if (abort_ctrl) begin
                // rot_count is kept so the host can see how far the scan got.
                r_state  <= StIdle;
                wrk_stat <= 1'b0;
                rot_en   <= 1'b0;
                adc_en   <= 1'b0;
                rf_sw    <= '0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (trg_ctrl && ch_mask != '0) begin
                            r_mask    <= ch_mask;
                            rot_count <= '0;
                            wrk_stat  <= 1'b1;
                            rot_en    <= 1'b1;
                            r_tcnt    <= '0;
                            r_state   <= StRotate;
`ifdef SCAN_ZIGZAG_EN
                            rot_dir   <= 1'b0;
`endif
                        end else if (trg_ctrl) begin
                            cfg_err <= 1'b1;
                        end
                    end
                    StRotate: begin
                        if (w_done) begin
                            rot_en  <= 1'b0;
                            r_tcnt  <= '0;
                            r_state <= StSettle;
                        end
                    end
                    StSettle: begin
                        if (w_done) begin
                            rf_sw   <= w_first_sw;
                            adc_ch  <= CH_W'(w_first);
                            r_tcnt  <= '0;
                            r_state <= StSwset;
                        end
                    end
                    StSwset: begin
                        if (w_done) begin
                            adc_en  <= 1'b1;
                            r_tcnt  <= '0;
                            r_state <= StAcq;
                        end
                    end
                    StAcq: begin
                        if (w_done) begin
                            adc_en <= 1'b0;
                            r_tcnt <= '0;
                            if (w_next >= 0) begin
                                rf_sw   <= w_next_sw;
                                adc_ch  <= CH_W'(w_next);
                                r_state <= StSwset;
                            end else begin
                                rf_sw     <= '0;
                                rot_count <= rot_count + 1'b1;
                                r_state   <= StCheck;
                            end
                        end
                    end
                    StCheck: begin
                        if (rot_count == ROT_END) begin
                            wrk_stat  <= 1'b0;
                            scan_done <= 1'b1;
                            r_state   <= StIdle;
                        end else begin
                            rot_en  <= 1'b1;
                            r_tcnt  <= '0;
                            r_state <= StRotate;
`ifdef SCAN_ZIGZAG_EN
                            rot_dir <= ~rot_dir;
`endif
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Bench for scan_seq_ctrl: random stp_clk timing; observed windows and tick counts are
// compared with a scan model built from the channel mask.
module tb_scan_seq_ctrl;

    localparam int N_CH  = 4;
    localparam int N_ROT = 3;
    localparam int ROT_T = 2;
    localparam int SET_T = 4;
    localparam int SW_T  = 1;
    localparam int ADC_T = 3;
`ifdef SCAN_ZIGZAG_EN
    localparam bit ZZ = 1'b1;
`else
    localparam bit ZZ = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] sw;
        logic [1:0] ch;
        logic       dir;
        logic [7:0] ticks;
    } win_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stp_clk = 1'b0;
    logic       trg = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] ch_mask = 4'b0;
    logic       wrk_stat, rot_en, adc_en, scan_done, cfg_err, rot_dir;
    logic [3:0] rf_sw;
    logic [1:0] adc_ch;
    logic [9:0] rot_count;

    int errors = 0;
    int checks = 0;

    scan_seq_ctrl #(
        .N_CH         (N_CH),
        .CNT_W        (10),
        .N_ROT        (N_ROT),
        .ROT_TICKS    (ROT_T),
        .SETTLE_TICKS (SET_T),
        .SW_TICKS     (SW_T),
        .ADC_TICKS    (ADC_T)
    ) dut (
        .fpga_clk      (clk),
        .sys_init_ctrl (rst),
        .stp_clk       (stp_clk),
        .trg_ctrl      (trg),
        .abort_ctrl    (abort),
        .ch_mask       (ch_mask),
        .wrk_stat      (wrk_stat),
        .rot_en        (rot_en),
        .adc_en        (adc_en),
        .rf_sw         (rf_sw),
        .adc_ch        (adc_ch),
        .rot_count     (rot_count),
        .scan_done     (scan_done),
        .cfg_err       (cfg_err)
`ifdef SCAN_ZIGZAG_EN
        ,
        .rot_dir       (rot_dir)
`endif
    );
`ifndef SCAN_ZIGZAG_EN
    assign rot_dir = 1'b0;
`endif

    always #5 clk = ~clk;

    // Step timebase with random high/low phases, changed away from both fpga_clk edges.
    bit stp_run = 1'b0;
    initial forever begin
        @(negedge clk);
        #1;
        if (stp_run) begin
            stp_clk = 1'b1;
            repeat ($urandom_range(3, 5)) @(negedge clk);
            #1;
            stp_clk = 1'b0;
            repeat ($urandom_range(3, 5)) @(negedge clk);
        end
    end

    // Monitor: stp_clk rises counted inside each adc_en / rot_en window and per position.
    win_t m_cur;
    win_t obs_win[$];
    int   obs_rot[$];
    int   obs_pos[$];
    int   rot_t, pos_t, done_cnt, cfg_cnt, rot_rises, mviol;
    bit   in_pos;
    logic m_rise, p_stp = 1'b0, p_adc = 1'b0, p_rot = 1'b0, p_wrk = 1'b0;

    always @(negedge clk) begin
        m_rise = stp_clk & ~p_stp;
        if ($countones(rf_sw) > 1) mviol++;
        if (adc_en && rf_sw == 4'b0) mviol++;
        if (adc_en && p_adc && (rf_sw != m_cur.sw || adc_ch != m_cur.ch)) mviol++;
        if (adc_en && !p_adc) begin
            m_cur.sw = rf_sw;
            m_cur.ch = adc_ch;
            m_cur.dir = rot_dir;
            m_cur.ticks = 8'd0;
        end
        if (adc_en && m_rise) m_cur.ticks = m_cur.ticks + 8'd1;
        if (!adc_en && p_adc) obs_win.push_back(m_cur);
        if (rot_en && !p_rot) begin
            rot_rises++;
            rot_t = 0;
            if (in_pos) obs_pos.push_back(pos_t);
            pos_t = 0;
            in_pos = 1'b1;
        end
        if (rot_en && m_rise) rot_t++;
        if (!rot_en && p_rot) obs_rot.push_back(rot_t);
        if (!wrk_stat && p_wrk && in_pos) begin
            obs_pos.push_back(pos_t);
            in_pos = 1'b0;
        end
        if (in_pos && m_rise) pos_t++;
        if (scan_done) done_cnt++;
        if (cfg_err) cfg_cnt++;
        p_stp = stp_clk;
        p_adc = adc_en;
        p_rot = rot_en;
        p_wrk = wrk_stat;
    end

    task automatic clear_mon();
        obs_win.delete();
        obs_rot.delete();
        obs_pos.delete();
        done_cnt = 0;
        cfg_cnt = 0;
        rot_rises = 0;
        mviol = 0;
        in_pos = 1'b0;
    endtask

    // Scan model: every position visits the set bits in order, reversed on odd positions
    // when zigzag is built in; a position lasts ROT+SETTLE+n*(SW+ADC) ticks.
    win_t exp_win[$];
    int   exp_pos[$];

    task automatic model_scan(input logic [3:0] mask);
        win_t w;
        exp_win.delete();
        exp_pos.delete();
        for (int p = 0; p < N_ROT; p++) begin
            bit rev = ZZ && (p % 2 == 1);
            int n = 0;
            for (int k = 0; k < N_CH; k++) begin
                int c = rev ? N_CH - 1 - k : k;
                if (mask[c]) begin
                    w.sw = 4'(1 << c);
                    w.ch = 2'(c);
                    w.dir = rev;
                    w.ticks = 8'(ADC_T);
                    exp_win.push_back(w);
                    n++;
                end
            end
            exp_pos.push_back(ROT_T + SET_T + n * (SW_T + ADC_T));
        end
    endtask

    task automatic start_scan(input logic [3:0] mask);
        stp_run = 1'b0;
        repeat (16) @(posedge clk);
        #2;
        clear_mon();
        ch_mask = mask;
        trg = 1'b1;
        @(posedge clk);
        #2;
        trg = 1'b0;
        stp_run = 1'b1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (wrk_stat !== 1'b0 && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (wrk_stat !== 1'b0) begin
            errors++;
            $display("FAIL %s timeout: wrk_stat=%b after %0d cycles, required 0", tag, wrk_stat, n);
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic run_scan_scenario(input string tag, input logic [3:0] mask, input bit scramble);
        model_scan(mask);
        start_scan(mask);
        checks++;
        if (wrk_stat !== 1'b1 || rot_en !== 1'b1) begin
            errors++;
            $display("FAIL %s start: wrk_stat=%b rot_en=%b, required 1 1", tag, wrk_stat, rot_en);
        end
        if (scramble) ch_mask = 4'($urandom);
        wait_idle(tag, 4000);
        checks++;
        if (obs_win.size() != exp_win.size()) begin
            errors++;
            $display("FAIL %s win_count: got %0d, required %0d", tag, obs_win.size(), exp_win.size());
        end else begin
            for (int i = 0; i < exp_win.size(); i++) begin
                checks++;
                if (obs_win[i] !== exp_win[i]) begin
                    errors++;
                    $display("FAIL %s win%0d: got sw=%b ch=%0d dir=%b ticks=%0d, required sw=%b ch=%0d dir=%b ticks=%0d",
                             tag, i, obs_win[i].sw, obs_win[i].ch, obs_win[i].dir, obs_win[i].ticks,
                             exp_win[i].sw, exp_win[i].ch, exp_win[i].dir, exp_win[i].ticks);
                end
            end
        end
        checks++;
        if (obs_rot.size() != N_ROT) begin
            errors++;
            $display("FAIL %s rot_windows: got %0d, required %0d", tag, obs_rot.size(), N_ROT);
        end else begin
            for (int i = 0; i < N_ROT; i++) begin
                checks++;
                if (obs_rot[i] != ROT_T) begin
                    errors++;
                    $display("FAIL %s rot%0d_ticks: got %0d, required %0d", tag, i, obs_rot[i], ROT_T);
                end
            end
        end
        checks++;
        if (obs_pos.size() != exp_pos.size()) begin
            errors++;
            $display("FAIL %s pos_count: got %0d, required %0d", tag, obs_pos.size(), exp_pos.size());
        end else begin
            for (int i = 0; i < exp_pos.size(); i++) begin
                checks++;
                if (obs_pos[i] != exp_pos[i]) begin
                    errors++;
                    $display("FAIL %s pos%0d_ticks: got %0d, required %0d", tag, i, obs_pos[i], exp_pos[i]);
                end
            end
        end
        checks++;
        if (rot_count !== 10'(N_ROT)) begin
            errors++;
            $display("FAIL %s rot_count: got %0d, required %0d", tag, rot_count, N_ROT);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL %s scan_done_pulses: got %0d, required 1", tag, done_cnt);
        end
        checks++;
        if (mviol != 0 || rf_sw !== 4'b0 || adc_en !== 1'b0) begin
            errors++;
            $display("FAIL %s invariants: violations=%0d rf_sw=%b adc_en=%b, required 0 0000 0",
                     tag, mviol, rf_sw, adc_en);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({wrk_stat, rot_en, adc_en, scan_done, cfg_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 00000",
                     {wrk_stat, rot_en, adc_en, scan_done, cfg_err});
        end
        checks++;
        if (rf_sw !== 4'b0 || adc_ch !== 2'b0 || rot_count !== 10'b0) begin
            errors++;
            $display("FAIL reset_values: rf_sw=%b adc_ch=%0d rot_count=%0d, required 0 0 0",
                     rf_sw, adc_ch, rot_count);
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (wrk_stat !== 1'b0 || rot_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: wrk_stat=%b rot_en=%b, required 0 0", wrk_stat, rot_en);
        end
    endtask

    task automatic test_full_mask();
        run_scan_scenario("full_mask", 4'b1111, 1'b0);
    endtask

    task automatic test_sparse_mask();
        run_scan_scenario("sparse_mask", 4'b1010, 1'b0);
    endtask

    task automatic test_random_masks();
        for (int i = 0; i < 3; i++)
            run_scan_scenario($sformatf("rand%0d", i), 4'($urandom_range(1, 15)), 1'b1);
    endtask

    task automatic test_cfg_err();
        stp_run = 1'b0;
        repeat (16) @(posedge clk);
        #2;
        clear_mon();
        ch_mask = 4'b0;
        trg = 1'b1;
        @(posedge clk);
        #2;
        trg = 1'b0;
        stp_run = 1'b1;
        checks++;
        if (cfg_err !== 1'b1 || wrk_stat !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_pulse: cfg_err=%b wrk_stat=%b, required 1 0", cfg_err, wrk_stat);
        end
        repeat (40) @(posedge clk);
        #2;
        checks++;
        if (cfg_cnt != 1 || rot_rises != 0 || wrk_stat !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_after: pulses=%0d rot_en_rises=%0d wrk_stat=%b, required 1 0 0",
                     cfg_cnt, rot_rises, wrk_stat);
        end
    endtask

    task automatic test_abort();
        int n = 0;
        int rises;
        start_scan(4'b1111);
        while (!(rot_count == 10'd1 && adc_en === 1'b1) && n < 4000) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (!(rot_count == 10'd1 && adc_en === 1'b1)) begin
            errors++;
            $display("FAIL abort_reach_acq: rot_count=%0d adc_en=%b, required 1 1", rot_count, adc_en);
        end
        abort = 1'b1;
        @(posedge clk);
        #2;
        abort = 1'b0;
        checks++;
        if ({rot_en, adc_en, wrk_stat} !== 3'b0 || rf_sw !== 4'b0) begin
            errors++;
            $display("FAIL abort_outputs: rot_en=%b adc_en=%b wrk_stat=%b rf_sw=%b, required 0 0 0 0000",
                     rot_en, adc_en, wrk_stat, rf_sw);
        end
        checks++;
        if (rot_count !== 10'd1) begin
            errors++;
            $display("FAIL abort_rot_count: got %0d, required 1", rot_count);
        end
        rises = rot_rises;
        repeat (150) @(posedge clk);
        #2;
        checks++;
        if (done_cnt != 0 || rot_rises != rises || wrk_stat !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: scan_done=%0d new_rot_en=%0d wrk_stat=%b, required 0 0 0",
                     done_cnt, rot_rises - rises, wrk_stat);
        end
        ch_mask = 4'b1111;
        abort = 1'b1;
        trg = 1'b1;
        @(posedge clk);
        #2;
        abort = 1'b0;
        trg = 1'b0;
        @(posedge clk);
        #2;
        checks++;
        if (wrk_stat !== 1'b0 || rot_count !== 10'd1) begin
            errors++;
            $display("FAIL abort_beats_trg: wrk_stat=%b rot_count=%0d, required 0 1", wrk_stat, rot_count);
        end
        start_scan(4'b0110);
        checks++;
        if (wrk_stat !== 1'b1 || rot_count !== 10'd0) begin
            errors++;
            $display("FAIL abort_restart: wrk_stat=%b rot_count=%0d, required 1 0", wrk_stat, rot_count);
        end
        wait_idle("abort_restart", 4000);
        checks++;
        if (done_cnt != 1 || rot_count !== 10'(N_ROT)) begin
            errors++;
            $display("FAIL abort_restart_done: pulses=%0d rot_count=%0d, required 1 %0d",
                     done_cnt, rot_count, N_ROT);
        end
    endtask

    task automatic test_reset_mid_settle();
        int n = 0;
        start_scan(4'b1111);
        while (!(obs_rot.size() >= 2 && rot_en === 1'b0) && n < 4000) begin
            @(posedge clk);
            #2;
            n++;
        end
        @(posedge clk);
        #2;
        checks++;
        if (rot_count !== 10'd1 || adc_ch !== 2'd3 || wrk_stat !== 1'b1) begin
            errors++;
            $display("FAIL settle_reach: rot_count=%0d adc_ch=%0d wrk_stat=%b, required 1 3 1",
                     rot_count, adc_ch, wrk_stat);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({wrk_stat, rot_en, adc_en, scan_done, cfg_err} !== 5'b0 || rf_sw !== 4'b0
            || adc_ch !== 2'b0 || rot_count !== 10'b0) begin
            errors++;
            $display("FAIL async_reset: flags=%b rf_sw=%b adc_ch=%0d rot_count=%0d, required all 0",
                     {wrk_stat, rot_en, adc_en, scan_done, cfg_err}, rf_sw, adc_ch, rot_count);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        run_scan_scenario("post_reset", 4'($urandom_range(1, 15)), 1'b0);
    endtask

`ifdef SCAN_ZIGZAG_EN
    task automatic test_zigzag();
        run_scan_scenario("zigzag", 4'b0101, 1'b0);
    endtask
`endif

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_full_mask();
        test_sparse_mask();
        test_cfg_err();
        test_abort();
        test_reset_mid_settle();
        test_random_masks();
`ifdef SCAN_ZIGZAG_EN
        test_zigzag();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
